can_frame_rx: RTL and testbench
===============================

Name: can_frame_rx

Overview:
- Receive stage directly downstream of the CAN node's transmitter.
- Samples the differential bus pair (can_hi_in/can_lo_in) at one bit per can_clk, in the same bit format the node transmits.
- Parses SOF, ID, control, DLC, data, CRC, tail and EOF fields, then presents a completed frame to the consumer (UART logger or host) over a valid/ready handshake.
- Flags framing errors, line errors and overruns.

Parameters:
- MAX_BYTES, 8, maximum data bytes captured; DLC values above this are clamped.
- EOF_BITS, 7, number of recessive EOF bits required.
- IDLE_BITS, 11, recessive bits required after an error before the next SOF is accepted.

Ports:
- can_clk  in  1  bit clock; one bus bit sampled per rising edge.
- reset  in  1  asynchronous, active-low reset.
- can_hi_in  in  1  bus high line.
- can_lo_in  in  1  bus low line.
- rx_ready  in  1  consumer accepts the frame.
- rx_valid  out  1  frame held on the outputs.
- rx_id  out  11  message ID.
- rx_dlc  out  4  raw received DLC.
- rx_data  out  64  data; byte k at [8k+:8]; bytes at or beyond the clamped DLC read 0.
- rx_err  out  1  one-cycle pulse on a frame error.
- rx_err_code  out  3  error cause; valid while rx_err is high.
- rx_overrun  out  1  one-cycle pulse when a completed frame is dropped.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Line decode:
  - hi=1, lo=0 → dominant, bit 0.
  - hi=0, lo=1 → recessive, bit 1.
  - hi==lo → line error (code 1), in any state except IDLE and ERROR.
- Frame field order, each field MSB first:
  - SOF(0), ID[11], CTRL[2] (must be 00), DLC[4], data 8×min(DLC,8) bits, CRC[15], TAIL[3] (must be 101), EOF (EOF_BITS ones).
- States:
  - IDLE → ID on a dominant bit.
  - ID → CTRL after 11 bits.
  - CTRL → DLC after 2 bits. Nonzero CTRL → ERROR, code 2.
  - DLC → DATA, or → CRC if DLC==0.
  - DATA → CRC after 8×min(DLC,8) bits.
  - CRC → TAIL after 15 bits.
  - TAIL → EOF after 3 bits. Mismatch from 101 → ERROR, code 3.
  - EOF → IDLE after EOF_BITS ones. Any 0 → ERROR, code 4.
  - ERROR → IDLE after IDLE_BITS consecutive recessive bits. The counter clears on each dominant bit.
- Bit counting: a single 7-bit bit counter, cleared on every state entry.
- Completion:
  - On the cycle after the last EOF bit, if rx_valid is low: load the output registers and set rx_valid.
  - If rx_valid is already high: assert rx_overrun for 1 cycle and keep the old frame.
- Handshake:
  - rx_valid stays high, with outputs stable, until a cycle where rx_valid && rx_ready; it clears on the next edge.
  - A new completion in the same cycle as an accept is loaded, not dropped.
- Reception continues while rx_valid is high. Shadow registers hold the in-progress frame separately from the output registers.
- rx_err: asserted for 1 cycle on the transition into ERROR. The shadow frame is discarded. The output registers are unaffected.
- Reset values:
  - rx_valid, rx_err, rx_overrun, busy = 0.
  - rx_id, rx_dlc, rx_data, rx_err_code = 0.
  - State = IDLE.
- Reset asserted mid-frame: the frame is dropped with no rx_err. After release, the block waits in IDLE for the next dominant bit.

Optional Feature:
- Macro: CAN_RX_CRC_CHECK_EN.
- Defined:
  - CRC-15 (poly 0x4599, init 0) is computed over SOF through the last data bit.
  - The CRC field is compared in TAIL; a mismatch → ERROR, code 5, evaluated on the first TAIL bit.
- Undefined:
  - The CRC field is shifted in and ignored; code 5 is never produced.
  - The CRC sub-module is not instantiated.

Decomposition:
- Package can_pkg:
  - State enumeration.
  - Error codes 1–5.
  - Field widths (ID 11, CTRL 2, DLC 4, CRC 15, TAIL 3).
  - CRC_POLY = 15'h4599 and TAIL_PATTERN = 3'b101.
  - Dominant/recessive encodings.
- Sub-module can_crc15:
  - Inputs: clk, reset, clear, enable, bit_in.
  - Output: crc[14:0].
  - Serial LFSR; shared with the transmitter for its CRC field.

Test Plan:
- Valid frame: ID 0x123, DLC 2, data 89 12, correct CRC, tail 101, 7 EOF ones, rx_ready=1 → rx_valid for 1 cycle after the last EOF bit; rx_id=0x123, rx_dlc=2, rx_data=0x0000_0000_0000_1289; no rx_err.
- Backpressure: two back-to-back valid frames (ID 0x123 then 0x456) with rx_ready=0 → first frame held stable, rx_overrun pulses once at the second completion; raise rx_ready → rx_valid clears next edge with rx_id=0x123.
- Tail fault: the same frame with tail 100 → rx_err=1, code 3; rx_valid stays 0; then 11 recessive bits followed by a valid frame → frame received normally.
- Line fault and reset: drive hi=lo=1 during the DLC field → rx_err, code 1. Separately, assert reset during DATA → no outputs; the next frame is received cleanly.
- DLC clamp: DLC 15 followed by 8 data bytes 01..08 → rx_dlc=15, rx_data=0x0807_0605_0403_0201, frame accepted.
- CRC check (CAN_RX_CRC_CHECK_EN defined): flip 1 CRC bit → rx_err, code 5. With the macro undefined, the same stimulus → frame accepted.

Source files
------------

// File: rtl/can_pkg.sv
// Shared definitions for the CAN frame receiver and its CRC helper.
// Contents: receiver state enumeration, error cause codes, field widths,
// CRC polynomial, tail pattern and dominant/recessive bit encodings.
package can_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StId,
    StCtrl,
    StDlc,
    StData,
    StCrc,
    StTail,
    StEof,
    StError
  } rx_state_e;

  // Error cause codes reported on rx_err_code
  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_LINE = 3'd1;
  localparam logic [2:0] ERR_CTRL = 3'd2;
  localparam logic [2:0] ERR_TAIL = 3'd3;
  localparam logic [2:0] ERR_EOF  = 3'd4;
  localparam logic [2:0] ERR_CRC  = 3'd5;

  // Field widths in bits
  localparam int unsigned ID_W   = 11;
  localparam int unsigned CTRL_W = 2;
  localparam int unsigned DLC_W  = 4;
  localparam int unsigned CRC_W  = 15;
  localparam int unsigned TAIL_W = 3;

  localparam logic [14:0] CRC_POLY     = 15'h4599;
  localparam logic [2:0]  TAIL_PATTERN = 3'b101;

  localparam logic BIT_DOMINANT  = 1'b0;
  localparam logic BIT_RECESSIVE = 1'b1;

endpackage

// File: rtl/can_crc15.sv
// Serial CRC-15 LFSR (CAN polynomial), one bit per enabled clock.
// Shared with the transmitter for generating its CRC field.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset (register cleared to 0)
//   clear  - synchronous clear to the initial value 0 (wins over enable)
//   enable - shift bit_in into the register this cycle
//   bit_in - serial message bit, MSB first
//   crc    - current CRC remainder
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [14:0] crc
);

  logic [14:0] crc_q, crc_d;
  logic        feedback;

  always_comb begin
    feedback = bit_in ^ crc_q[14];
    crc_d    = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = {crc_q[13:0], 1'b0} ^ (feedback ? CRC_POLY : 15'h0000);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_frame_rx.sv
// CAN frame receiver: samples the differential bus one bit per can_clk,
// parses SOF/ID/CTRL/DLC/DATA/CRC/TAIL/EOF and hands completed frames to a
// consumer over a valid/ready handshake. Reception continues while a frame
// is held; the in-progress frame lives in shadow registers.
// Optional: define CAN_RX_CRC_CHECK_EN to check the received CRC field.
// Ports:
//   can_clk, reset       - bit clock, asynchronous active-low reset
//   can_hi_in, can_lo_in - bus pair (hi=1/lo=0 dominant, hi=0/lo=1 recessive)
//   rx_ready / rx_valid  - consumer handshake
//   rx_id, rx_dlc        - held frame ID and raw DLC
//   rx_data              - held data, byte k at [8k+:8], unused bytes zero
//   rx_err, rx_err_code  - one-cycle error pulse and its cause
//   rx_overrun           - one-cycle pulse when a completed frame is dropped
//   busy                 - receiver is not idle
module can_frame_rx
  import can_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned EOF_BITS  = 7,
  parameter int unsigned IDLE_BITS = 11
) (
  input  logic        can_clk,
  input  logic        reset,
  input  logic        can_hi_in,
  input  logic        can_lo_in,
  input  logic        rx_ready,
  output logic        rx_valid,
  output logic [10:0] rx_id,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        rx_err,
  output logic [2:0]  rx_err_code,
  output logic        rx_overrun,
  output logic        busy
);

  localparam logic [6:0] IdLast   = 7'(ID_W - 1);
  localparam logic [6:0] CtrlLast = 7'(CTRL_W - 1);
  localparam logic [6:0] DlcLast  = 7'(DLC_W - 1);
  localparam logic [6:0] CrcLast  = 7'(CRC_W - 1);
  localparam logic [6:0] TailLast = 7'(TAIL_W - 1);
  localparam logic [6:0] EofLast  = 7'(EOF_BITS - 1);
  localparam logic [6:0] IdleLast = 7'(IDLE_BITS - 1);
  localparam logic [3:0] MaxBytes = 4'(MAX_BYTES);

  rx_state_e   state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [10:0] id_q, id_d;
  logic [3:0]  dlc_q, dlc_d;
  logic [63:0] data_q, data_d;
  logic        ctrl_nz_q, ctrl_nz_d;
  logic [1:0]  tail_q, tail_d;

  logic        rx_valid_q, rx_valid_d;
  logic [10:0] rx_id_q, rx_id_d;
  logic [3:0]  rx_dlc_q, rx_dlc_d;
  logic [63:0] rx_data_q, rx_data_d;
  logic        rx_err_q;
  logic [2:0]  rx_err_code_q, rx_err_code_d;
  logic        rx_overrun_q, rx_overrun_d;

  logic        line_ok, rx_bit;
  logic        err_set;
  logic [2:0]  err_code;
  logic        complete;
  logic [3:0]  n_bytes;
  logic [6:0]  data_last;
  logic [5:0]  data_idx;

  assign line_ok = can_hi_in ^ can_lo_in;
  assign rx_bit  = can_lo_in;

  // Data bytes arrive MSB first; byte k lands at [8k+:8].
  assign n_bytes   = (dlc_q > MaxBytes) ? MaxBytes : dlc_q;
  assign data_last = {n_bytes, 3'b000} - 7'd1;
  assign data_idx  = {cnt_q[5:3], ~cnt_q[2:0]};

`ifdef CAN_RX_CRC_CHECK_EN
  logic        crc_clear, crc_en;
  logic [14:0] crc_calc, crc_rx_q, crc_rx_d;

  // SOF is dominant and the LFSR starts at 0, so skipping the SOF bit
  // leaves the remainder unchanged.
  assign crc_clear = (state_q == StIdle);
  assign crc_en    = (state_q inside {StId, StCtrl, StDlc, StData});

  can_crc15 u_crc (
    .clk    (can_clk),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .bit_in (rx_bit),
    .crc    (crc_calc)
  );
`endif

  // Frame parser
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 7'd1;
    id_d      = id_q;
    dlc_d     = dlc_q;
    data_d    = data_q;
    ctrl_nz_d = ctrl_nz_q;
    tail_d    = tail_q;
    err_set   = 1'b0;
    err_code  = ERR_NONE;
    complete  = 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
    crc_rx_d  = crc_rx_q;
`endif

    if (state_q != StIdle && state_q != StError && !line_ok) begin
      err_set  = 1'b1;
      err_code = ERR_LINE;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (line_ok && rx_bit == BIT_DOMINANT) begin
            state_d = StId;
            data_d  = '0;
          end
        end
        StId: begin
          id_d = {id_q[9:0], rx_bit};
          if (cnt_q == IdLast) state_d = StCtrl;
        end
        StCtrl: begin
          ctrl_nz_d = ((cnt_q == 7'd0) ? 1'b0 : ctrl_nz_q) | rx_bit;
          if (cnt_q == CtrlLast) begin
            if (ctrl_nz_d) begin
              err_set  = 1'b1;
              err_code = ERR_CTRL;
            end else begin
              state_d = StDlc;
            end
          end
        end
        StDlc: begin
          dlc_d = {dlc_q[2:0], rx_bit};
          if (cnt_q == DlcLast) state_d = (dlc_d == 4'd0) ? StCrc : StData;
        end
        StData: begin
          data_d[data_idx] = rx_bit;
          if (cnt_q == data_last) state_d = StCrc;
        end
        StCrc: begin
`ifdef CAN_RX_CRC_CHECK_EN
          crc_rx_d = {crc_rx_q[13:0], rx_bit};
`endif
          if (cnt_q == CrcLast) state_d = StTail;
        end
        StTail: begin
          tail_d = {tail_q[0], rx_bit};
`ifdef CAN_RX_CRC_CHECK_EN
          if (cnt_q == 7'd0 && crc_rx_q != crc_calc) begin
            err_set  = 1'b1;
            err_code = ERR_CRC;
          end else
`endif
          if (cnt_q == TailLast) begin
            if ({tail_q, rx_bit} != TAIL_PATTERN) begin
              err_set  = 1'b1;
              err_code = ERR_TAIL;
            end else begin
              state_d = StEof;
            end
          end
        end
        StEof: begin
          if (rx_bit == BIT_DOMINANT) begin
            err_set  = 1'b1;
            err_code = ERR_EOF;
          end else if (cnt_q == EofLast) begin
            state_d  = StIdle;
            complete = 1'b1;
          end
        end
        StError: begin
          // Count consecutive clean recessive bits; anything else restarts.
          if (line_ok && rx_bit == BIT_RECESSIVE) begin
            if (cnt_q == IdleLast) state_d = StIdle;
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (err_set) state_d = StError;
    if (state_d != state_q) cnt_d = '0;
  end

  // Output handshake; a completion coinciding with an accept is loaded.
  always_comb begin
    rx_valid_d    = rx_valid_q & ~rx_ready;
    rx_id_d       = rx_id_q;
    rx_dlc_d      = rx_dlc_q;
    rx_data_d     = rx_data_q;
    rx_overrun_d  = 1'b0;
    rx_err_code_d = err_set ? err_code : rx_err_code_q;
    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_valid_d = 1'b1;
        rx_id_d    = id_q;
        rx_dlc_d   = dlc_q;
        rx_data_d  = data_q;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge can_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      id_q          <= '0;
      dlc_q         <= '0;
      data_q        <= '0;
      ctrl_nz_q     <= 1'b0;
      tail_q        <= '0;
      rx_valid_q    <= 1'b0;
      rx_id_q       <= '0;
      rx_dlc_q      <= '0;
      rx_data_q     <= '0;
      rx_err_q      <= 1'b0;
      rx_err_code_q <= '0;
      rx_overrun_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      dlc_q         <= dlc_d;
      data_q        <= data_d;
      ctrl_nz_q     <= ctrl_nz_d;
      tail_q        <= tail_d;
      rx_valid_q    <= rx_valid_d;
      rx_id_q       <= rx_id_d;
      rx_dlc_q      <= rx_dlc_d;
      rx_data_q     <= rx_data_d;
      rx_err_q      <= err_set;
      rx_err_code_q <= rx_err_code_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

`ifdef CAN_RX_CRC_CHECK_EN
  always_ff @(posedge can_clk or negedge reset) begin
    if (!reset) begin
      crc_rx_q <= '0;
    end else begin
      crc_rx_q <= crc_rx_d;
    end
  end
`endif

  assign rx_valid    = rx_valid_q;
  assign rx_id       = rx_id_q;
  assign rx_dlc      = rx_dlc_q;
  assign rx_data     = rx_data_q;
  assign rx_err      = rx_err_q;
  assign rx_err_code = rx_err_code_q;
  assign rx_overrun  = rx_overrun_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_can_frame_rx.sv
// Testbench for can_frame_rx: frames are built bit by bit from field values,
// the expected outcome is decided from the frame contents and pushed into
// scoreboard queues, and a monitor pops and compares on every DUT event.
module tb_can_frame_rx;

  localparam int F_NONE = 0;
  localparam int F_CTRL = 1;
  localparam int F_TAIL = 2;
  localparam int F_EOF  = 3;
  localparam int F_CRC  = 4;
  localparam int F_LINE = 5;

  typedef struct {
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frame_t;

  logic        can_clk;
  logic        reset;
  logic        can_hi_in;
  logic        can_lo_in;
  logic        rx_ready;
  logic        rx_valid;
  logic [10:0] rx_id;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic        rx_err;
  logic [2:0]  rx_err_code;
  logic        rx_overrun;
  logic        busy;

  int     checks;
  int     errors;
  frame_t exp_frames[$];
  int     exp_errs[$];
  int     exp_ovr;
  bit     model_valid;
  bit     frame_bits[$];

  can_frame_rx dut (
    .can_clk     (can_clk),
    .reset       (reset),
    .can_hi_in   (can_hi_in),
    .can_lo_in   (can_lo_in),
    .rx_ready    (rx_ready),
    .rx_valid    (rx_valid),
    .rx_id       (rx_id),
    .rx_dlc      (rx_dlc),
    .rx_data     (rx_data),
    .rx_err      (rx_err),
    .rx_err_code (rx_err_code),
    .rx_overrun  (rx_overrun),
    .busy        (busy)
  );

  initial begin
    can_clk = 1'b0;
    forever #5 can_clk = ~can_clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event (value %0h), required none", name, act);
  endtask

  // CRC as the remainder of (message * x^15) divided by x^15 + 0x4599.
  function automatic logic [14:0] crc_ref(input int n);
    bit          w[$];
    logic [15:0] g;
    logic [14:0] r;
    g = 16'hC599;
    for (int i = 0; i < n; i++) w.push_back(frame_bits[i]);
    for (int i = 0; i < 15; i++) w.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (w[i]) begin
        for (int j = 0; j < 16; j++) w[i+j] = w[i+j] ^ g[15-j];
      end
    end
    for (int j = 0; j < 15; j++) r[14-j] = w[n+j];
    return r;
  endfunction

  task automatic drive(input logic hi, input logic lo);
    can_hi_in = hi;
    can_lo_in = lo;
    @(posedge can_clk);
    #1;
  endtask

  // Builds and sends one frame; stop_at >= 0 truncates it and expects nothing.
  task automatic send_frame(input logic [10:0] id, input logic [3:0] dlc,
                            input logic [63:0] payload, input int fault, input int arg,
                            input int gap, input int stop_at);
    int          nb;
    int          line_pos;
    int          code;
    logic [1:0]  ctrl;
    logic [14:0] crc;
    logic [2:0]  tail;
    logic [6:0]  eof;
    logic [63:0] exp_data;
    frame_t      f;

    frame_bits.delete();
    frame_bits.push_back(1'b0);
    for (int i = 10; i >= 0; i--) frame_bits.push_back(id[i]);
    ctrl = (fault == F_CTRL) ? 2'(arg % 3 + 1) : 2'b00;
    for (int i = 1; i >= 0; i--) frame_bits.push_back(ctrl[i]);
    for (int i = 3; i >= 0; i--) frame_bits.push_back(dlc[i]);
    nb = (dlc > 4'd8) ? 8 : int'(dlc);
    exp_data = '0;
    for (int b = 0; b < nb; b++) begin
      for (int i = 7; i >= 0; i--) frame_bits.push_back(payload[8*b+i]);
      exp_data[8*b+:8] = payload[8*b+:8];
    end
    crc = crc_ref(frame_bits.size());
    if (fault == F_CRC) crc[arg % 15] = ~crc[arg % 15];
    for (int i = 14; i >= 0; i--) frame_bits.push_back(crc[i]);
    tail = 3'b101;
    if (fault == F_TAIL) tail = tail ^ 3'(arg % 7 + 1);
    for (int i = 2; i >= 0; i--) frame_bits.push_back(tail[i]);
    eof = '1;
    if (fault == F_EOF) eof[arg % 7] = 1'b0;
    for (int i = 0; i < 7; i++) frame_bits.push_back(eof[i]);
    line_pos = (fault == F_LINE) ? 1 + arg % (frame_bits.size() - 1) : -1;

    case (fault)
      F_LINE:  code = 1;
      F_CTRL:  code = 2;
      F_TAIL:  code = 3;
      F_EOF:   code = 4;
`ifdef CAN_RX_CRC_CHECK_EN
      F_CRC:   code = 5;
`endif
      default: code = 0;
    endcase

    if (stop_at < 0) begin
      if (code != 0) begin
        exp_errs.push_back(code);
      end else if (model_valid && !rx_ready) begin
        exp_ovr++;
      end else begin
        f.id   = id;
        f.dlc  = dlc;
        f.data = exp_data;
        exp_frames.push_back(f);
        model_valid = !rx_ready;
      end
    end

    for (int k = 0; k < frame_bits.size(); k++) begin
      if (k == stop_at) return;
      if (k == line_pos) drive(1'b1, 1'b1);
      else drive(~frame_bits[k], frame_bits[k]);
    end
    repeat (gap) drive(1'b0, 1'b1);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge can_clk) begin
    frame_t f;
    int     e;
    if (rx_err) begin
      if (exp_errs.size() == 0) begin
        unexpected("rx_err", 64'(rx_err_code));
      end else begin
        e = exp_errs.pop_front();
        check("err_code", 64'(rx_err_code), 64'(e));
      end
    end
    if (rx_overrun) begin
      if (exp_ovr == 0) begin
        unexpected("rx_overrun", 64'(rx_id));
      end else begin
        exp_ovr--;
        check("overrun_valid_held", 64'(rx_valid), 64'(1));
      end
    end
    if (rx_valid) begin
      if (exp_frames.size() == 0) begin
        unexpected("rx_valid", 64'(rx_id));
      end else if (rx_ready) begin
        f = exp_frames.pop_front();
        check("frame_id", 64'(rx_id), 64'(f.id));
        check("frame_dlc", 64'(rx_dlc), 64'(f.dlc));
        check("frame_data", rx_data, f.data);
      end else begin
        check("hold_id", 64'(rx_id), 64'(exp_frames[0].id));
        check("hold_data", rx_data, exp_frames[0].data);
      end
    end
  end

  initial begin
    int          fault;
    int          gap;
    logic [63:0] pl;
    checks      = 0;
    errors      = 0;
    exp_ovr     = 0;
    model_valid = 1'b0;
    reset       = 1'b0;
    can_hi_in   = 1'b0;
    can_lo_in   = 1'b1;
    rx_ready    = 1'b1;
    repeat (3) @(posedge can_clk);
    #1;
    check("reset_valid", 64'(rx_valid), 64'(0));
    check("reset_err", 64'(rx_err), 64'(0));
    check("reset_overrun", 64'(rx_overrun), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_id", 64'(rx_id), 64'(0));
    check("reset_dlc", 64'(rx_dlc), 64'(0));
    check("reset_data", rx_data, 64'(0));
    check("reset_code", 64'(rx_err_code), 64'(0));
    reset = 1'b1;
    repeat (2) drive(1'b0, 1'b1);

    // Valid frame: rx_valid for exactly one cycle with ready high
    send_frame(11'h123, 4'd2, 64'h1289, F_NONE, 0, 0, -1);
    check("valid_after_eof", 64'(rx_valid), 64'(1));
    drive(1'b0, 1'b1);
    check("valid_one_cycle", 64'(rx_valid), 64'(0));
    repeat (3) drive(1'b0, 1'b1);

    // Backpressure: second frame dropped, first held
    rx_ready = 1'b0;
    send_frame(11'h123, 4'd2, 64'h1289, F_NONE, 0, 0, -1);
    send_frame(11'h456, 4'd1, 64'h00AB, F_NONE, 0, 0, -1);
    drive(1'b0, 1'b1);
    check("bp_valid_held", 64'(rx_valid), 64'(1));
    check("bp_id_held", 64'(rx_id), 64'(11'h123));
    rx_ready = 1'b1;
    drive(1'b0, 1'b1);
    check("bp_valid_cleared", 64'(rx_valid), 64'(0));
    model_valid = 1'b0;
    repeat (2) drive(1'b0, 1'b1);

    // Tail 100, then recovery with a clean frame
    send_frame(11'h123, 4'd2, 64'h1289, F_TAIL, 0, 12, -1);
    check("tail_no_valid", 64'(rx_valid), 64'(0));
    send_frame(11'h123, 4'd2, 64'h1289, F_NONE, 0, 3, -1);

    // Line fault inside DLC (bit 15 of the frame)
    send_frame(11'h2A5, 4'd3, 64'h00C0FFEE, F_LINE, 14, 12, -1);

    // Reset in the middle of DATA
    send_frame(11'h3C3, 4'd2, 64'h5AA5, F_NONE, 0, 0, 23);
    check("busy_mid_data", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    check("reset_mid_busy", 64'(busy), 64'(0));
    check("reset_mid_valid", 64'(rx_valid), 64'(0));
    can_hi_in = 1'b0;
    can_lo_in = 1'b1;
    repeat (2) @(posedge can_clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 1'b1);
    send_frame(11'h3C3, 4'd2, 64'h5AA5, F_NONE, 0, 3, -1);

    // DLC clamp
    send_frame(11'h7FF, 4'd15, 64'h0807060504030201, F_NONE, 0, 3, -1);

    // Single flipped CRC bit
    send_frame(11'h123, 4'd2, 64'h1289, F_CRC, 3, 12, -1);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      case (r)
        5:       fault = F_CTRL;
        6:       fault = F_TAIL;
        7:       fault = F_EOF;
        8:       fault = F_CRC;
        9:       fault = F_LINE;
        default: fault = F_NONE;
      endcase
      gap = (fault == F_NONE) ? int'($urandom_range(0, 3)) : 12 + int'($urandom_range(0, 3));
      pl  = {$urandom, $urandom};
      send_frame(11'($urandom), 4'($urandom_range(0, 15)), pl, fault,
                 int'($urandom_range(0, 1000)), gap, -1);
    end

    repeat (5) drive(1'b0, 1'b1);
    check("frames_outstanding", 64'(exp_frames.size()), 64'(0));
    check("errors_outstanding", 64'(exp_errs.size()), 64'(0));
    check("overruns_outstanding", 64'(exp_ovr), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
